// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode controls/operands, resolves the destination,
// detects load-use hazards. Optional perf counters enabled by `define ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_reg_write,
    input  logic          id_mem_to_reg,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_reg_dst,
    input  logic          id_alu_src,
    input  logic [3:0]    id_pc_src,
    input  logic [4:0]    id_alu_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [DW-1:0] id_pc4,
    input  logic          ex_stall,
    input  logic          flush,
    output logic          id_ready,
    output logic          load_use_stall,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_to_reg,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic [3:0]    ex_pc_src,
    output logic [4:0]    ex_alu_op,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_dst,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [4:0]    ex_shamt,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] hold_cnt
);

    localparam logic [3:0]    PC_SRC_JAL = 4'b0111;
    localparam logic [RW-1:0] RA_IDX     = RW'(31);

    logic          uses_rt;
    logic [RW-1:0] dst_sel;
    logic          clear;

    // Destination: $31 for jal, otherwise rt (I-type) or rd (R-type)
    always_comb begin
        dst_sel = id_rd;
        if (id_pc_src == PC_SRC_JAL) begin
            dst_sel = RA_IDX;
        end else if (id_reg_dst) begin
            dst_sel = id_rt;
        end
    end

    assign uses_rt        = !(id_alu_src && !id_mem_write);
    assign load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_dst != '0) &&
                            ((ex_dst == id_rs) || (uses_rt && (ex_dst == id_rt)));
    assign id_ready       = !ex_stall && !load_use_stall;

    // Bubble on reset/flush; otherwise hold wins over hazard and empty-slot bubbles
    assign clear = rst || flush || (!ex_stall && (load_use_stall || !id_valid));

    always_ff @(posedge clk) begin
        if (clear) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_pc_src     <= '0;
            ex_alu_op     <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
            ex_shamt      <= '0;
        end else if (!ex_stall) begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= id_reg_write && (dst_sel != '0);
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_pc_src     <= id_pc_src;
            ex_alu_op     <= id_alu_op;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dst        <= dst_sel;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_pc4        <= id_pc4;
            ex_shamt      <= id_shamt;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic          bubble_ev;
    logic          hold_ev;
    logic [CW-1:0] bubble_q;
    logic [CW-1:0] hold_q;

    assign bubble_ev = flush || (!ex_stall && load_use_stall);
    assign hold_ev   = ex_stall && !flush;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
            hold_q   <= '0;
        end else begin
            if (bubble_ev && (bubble_q != '1)) bubble_q <= bubble_q + CW'(1);
            if (hold_ev && (hold_q != '1))     hold_q   <= hold_q + CW'(1);
        end
    end

    assign bubble_cnt = bubble_q;
    assign hold_cnt   = hold_q;
`else
    assign bubble_cnt = '0;
    assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic          id_reg_dst, id_alu_src;
    logic [3:0]    id_pc_src;
    logic [4:0]    id_alu_op;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]    id_shamt;
    logic          ex_stall, flush;
    logic          id_ready, load_use_stall, ex_valid;
    logic          ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]    ex_pc_src;
    logic [4:0]    ex_alu_op;
    logic [RW-1:0] ex_rs, ex_rt, ex_dst;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]    ex_shamt;
    logic [CW-1:0] bubble_cnt, hold_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_bubble = 0;
    int exp_hold   = 0;

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
        .id_pc_src(id_pc_src), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_pc4(id_pc4),
        .ex_stall(ex_stall), .flush(flush),
        .id_ready(id_ready), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_pc_src(ex_pc_src), .ex_alu_op(ex_alu_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_shamt(ex_shamt), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_cnt(input string tag);
`ifdef ID_EX_PERF_CNT_EN
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(exp_bubble));
        check({tag, ".hold_cnt"},   64'(hold_cnt),   64'(exp_hold));
`else
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
        check({tag, ".hold_cnt"},   64'(hold_cnt),   64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_valid = 1'b1; id_reg_write = 1'b0; id_mem_to_reg = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_reg_dst = 1'b0; id_alu_src = 1'b0;
        id_pc_src = 4'd0; id_alu_op = 5'd0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = 5'd0; id_pc4 = 32'h100;
    endtask

    task automatic op_r(input int rs, input int rt, input int rd);
        clr_id();
        id_reg_write = 1'b1; id_rs = RW'(rs); id_rt = RW'(rt); id_rd = RW'(rd);
        id_rs_data = 32'(rs) + 32'd1000; id_rt_data = 32'(rt) + 32'd2000;
    endtask

    task automatic op_i(input int rs, input int rt, input int imm);
        clr_id();
        id_reg_write = 1'b1; id_reg_dst = 1'b1; id_alu_src = 1'b1; id_alu_op = 5'b00001;
        id_rs = RW'(rs); id_rt = RW'(rt); id_imm = 32'(imm);
    endtask

    task automatic op_lw(input int rs, input int rt);
        op_i(rs, rt, 0);
        id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_alu_op = 5'b00010;
    endtask

    task automatic op_sw(input int rs, input int rt, input int imm);
        op_i(rs, rt, imm);
        id_reg_write = 1'b0; id_mem_write = 1'b1; id_alu_op = 5'b00010;
    endtask

    initial begin
        clr_id();
        ex_stall = 1'b0; flush = 1'b0; rst = 1'b1;
        op_r(1, 2, 3);
        id_pc4 = 32'h104;
        step(); step();
        check("rst.ex_valid", 64'(ex_valid), 64'd0);
        check("rst.ex_dst", 64'(ex_dst), 64'd0);
        check("rst.ex_reg_write", 64'(ex_reg_write), 64'd0);
        check("rst.ex_rs_data", 64'(ex_rs_data), 64'd0);
        check("rst.ex_pc4", 64'(ex_pc4), 64'd0);
        check_cnt("rst");

        rst = 1'b0;
        #1;
        check("add.id_ready", 64'(id_ready), 64'd1);
        step();
        check("add.ex_valid", 64'(ex_valid), 64'd1);
        check("add.ex_dst", 64'(ex_dst), 64'd3);
        check("add.ex_alu_op", 64'(ex_alu_op), 64'd0);
        check("add.ex_reg_write", 64'(ex_reg_write), 64'd1);
        check("add.ex_rs_data", 64'(ex_rs_data), 64'd1001);
        check("add.ex_pc4", 64'(ex_pc4), 64'h104);

        op_i(4, 5, 7);
        step();
        check("addi.ex_dst", 64'(ex_dst), 64'd5);
        check("addi.ex_imm", 64'(ex_imm), 64'd7);
        check("addi.ex_alu_src", 64'(ex_alu_src), 64'd1);

        // lw $8,0($9) then dependent add $10,$8,$1
        op_lw(9, 8);
        step();
        check("lw.ex_mem_read", 64'(ex_mem_read), 64'd1);
        op_r(8, 1, 10);
        #1;
        check("lu.stall", 64'(load_use_stall), 64'd1);
        check("lu.id_ready", 64'(id_ready), 64'd0);
        step();
        exp_bubble++;
        check("lu.bubble_valid", 64'(ex_valid), 64'd0);
        check("lu.bubble_mem_read", 64'(ex_mem_read), 64'd0);
        check("lu.bubble_reg_write", 64'(ex_reg_write), 64'd0);
        check("lu.stall_cleared", 64'(load_use_stall), 64'd0);
        step();
        check("lu.add_valid", 64'(ex_valid), 64'd1);
        check("lu.add_rs", 64'(ex_rs), 64'd8);
        check("lu.add_dst", 64'(ex_dst), 64'd10);
        check_cnt("lu");

        // lw $8 then addi $8,$0,5: rt is a destination, no hazard
        op_lw(9, 8);
        step();
        op_i(0, 8, 5);
        #1;
        check("noru.stall", 64'(load_use_stall), 64'd0);
        step();
        check("noru.ex_dst", 64'(ex_dst), 64'd8);
        check("noru.ex_valid", 64'(ex_valid), 64'd1);

        // lw $0 never stalls
        op_lw(9, 0);
        step();
        check("lw0.ex_reg_write", 64'(ex_reg_write), 64'd0);
        op_r(0, 0, 4);
        #1;
        check("lw0.stall", 64'(load_use_stall), 64'd0);
        step();
        check("lw0.next_dst", 64'(ex_dst), 64'd4);

        // sw uses rt: lw $8 then sw $8,4($2) stalls
        op_lw(9, 8);
        step();
        op_sw(2, 8, 4);
        #1;
        check("sw.stall", 64'(load_use_stall), 64'd1);
        step();
        exp_bubble++;
        check("sw.bubble", 64'(ex_valid), 64'd0);
        step();
        check("sw.ex_mem_write", 64'(ex_mem_write), 64'd1);
        check("sw.ex_rt", 64'(ex_rt), 64'd8);

        // jal writes $31
        clr_id();
        id_pc_src = 4'b0111; id_reg_write = 1'b1; id_pc4 = 32'h200;
        step();
        check("jal.ex_dst", 64'(ex_dst), 64'd31);
        check("jal.ex_reg_write", 64'(ex_reg_write), 64'd1);
        check("jal.ex_pc_src", 64'(ex_pc_src), 64'd7);

        op_r(1, 2, 0);
        step();
        check("rd0.ex_reg_write", 64'(ex_reg_write), 64'd0);
        check("rd0.ex_valid", 64'(ex_valid), 64'd1);

        op_r(1, 2, 6);
        id_valid = 1'b0;
        step();
        check("inv.ex_valid", 64'(ex_valid), 64'd0);
        check("inv.ex_reg_write", 64'(ex_reg_write), 64'd0);

        // hold for 3 cycles, flush in the 2nd
        op_i(4, 5, 7);
        step();
        ex_stall = 1'b1;
        op_r(1, 2, 12);
        #1;
        check("hold.id_ready", 64'(id_ready), 64'd0);
        step();
        exp_hold++;
        check("hold1.ex_dst", 64'(ex_dst), 64'd5);
        check("hold1.ex_imm", 64'(ex_imm), 64'd7);
        check("hold1.ex_valid", 64'(ex_valid), 64'd1);
        check_cnt("hold1");
        op_r(3, 4, 13);
        flush = 1'b1;
        step();
        exp_bubble++;
        check("hold2.flush_valid", 64'(ex_valid), 64'd0);
        check("hold2.flush_dst", 64'(ex_dst), 64'd0);
        flush = 1'b0;
        op_r(5, 6, 14);
        step();
        exp_hold++;
        check("hold3.ex_valid", 64'(ex_valid), 64'd0);
        check_cnt("hold3");
        ex_stall = 1'b0;
        #1;
        check("release.id_ready", 64'(id_ready), 64'd1);
        step();
        check("release.ex_dst", 64'(ex_dst), 64'd14);
        check("release.ex_valid", 64'(ex_valid), 64'd1);
        check_cnt("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
